// File: rtl/fir_mul_arbiter.sv
// fir_mul_arbiter: round-robin share of one pipelined multiplier between FIR taps.
// Optional per-requester grant counters: define FIR_MUL_ARB_GRANT_CNT_EN.
module fir_mul_arbiter #(
  parameter int N_REQ          = 4,
  parameter int BITWIDTH_INPUT = 16,
  parameter int MUL_LATENCY    = 7
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ*BITWIDTH_INPUT-1:0]     req_a,
  input  logic [N_REQ*BITWIDTH_INPUT-1:0]     req_b,
  output logic [BITWIDTH_INPUT-1:0]           mul_a,
  output logic [BITWIDTH_INPUT-1:0]           mul_b,
  input  logic [2*BITWIDTH_INPUT-1:0]         mul_q,
  output logic                                res_valid,
  output logic [$clog2(N_REQ)-1:0]            res_id,
  output logic [2*BITWIDTH_INPUT-1:0]         res_q,
  input  logic                                flush,
  output logic                                idle,
  output logic [$clog2(MUL_LATENCY+2)-1:0]    inflight,
  output logic [N_REQ*32-1:0]                 grant_cnt
);

  localparam int W    = BITWIDTH_INPUT;
  localparam int IDW  = $clog2(N_REQ);
  localparam int INFW = $clog2(MUL_LATENCY+2);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_IDLE} state_e;

  state_e          r_state, w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [W-1:0]    r_mul_a, r_mul_b;
  logic            r_tag_v  [MUL_LATENCY+1];
  logic [IDW-1:0]  r_tag_id [MUL_LATENCY+1];
  logic [INFW-1:0] r_inflight, w_inflight_nxt;

  logic               w_en, w_any, w_fire, w_ret;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDW-1:0]     w_off, w_gnt, w_rr_nxt;
  logic [IDW:0]       w_sum, w_sum_wrap;
  logic [W-1:0]       w_a, w_b;

  assign w_en  = rstn && (r_state == S_RUN) && !flush;
  assign w_dbl = {req_valid, req_valid} >> r_rr_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  // Lowest set bit of the rotated request vector is the offset from rr_ptr.
  always_comb begin
    w_off = '0;
    w_any = 1'b0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDW'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_sum_wrap = w_sum - NREQ_W;
  assign w_gnt      = (w_sum >= NREQ_W) ? w_sum_wrap[IDW-1:0]
                                        : w_sum[IDW-1:0];
  assign w_fire     = w_en & w_any;
  assign w_rr_nxt   = (w_gnt == IDW'(N_REQ-1)) ? '0 : w_gnt + 1'b1;
  assign w_ret      = r_tag_v[MUL_LATENCY];

  always_comb begin
    req_ready = '0;
    if (w_fire) req_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_a = req_a[i*W +: W];
        w_b = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    unique case ({w_fire, w_ret})
      2'b10:   w_inflight_nxt = r_inflight + INFW'(1);
      2'b01:   w_inflight_nxt = r_inflight - INFW'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (flush) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_inflight_nxt == '0) w_state_nxt = S_IDLE;
      S_IDLE:  if (!flush) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_RUN;
      r_rr_ptr   <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_inflight <= '0;
      for (int i = 0; i <= MUL_LATENCY; i++) begin
        r_tag_v[i]  <= 1'b0;
        r_tag_id[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_inflight_nxt;
      if (w_fire) begin
        r_rr_ptr <= w_rr_nxt;
        r_mul_a  <= w_a;
        r_mul_b  <= w_b;
      end
      r_tag_v[0]  <= w_fire;
      r_tag_id[0] <= w_gnt;
      for (int i = 1; i <= MUL_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign res_valid = w_ret;
  assign res_id    = w_ret ? r_tag_id[MUL_LATENCY] : '0;
  assign res_q     = w_ret ? mul_q : '0;
  assign idle      = (r_state == S_IDLE);
  assign inflight  = r_inflight;

`ifdef FIR_MUL_ARB_GRANT_CNT_EN
  logic [31:0] r_cnt [N_REQ];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else if (w_fire) begin
      r_cnt[w_gnt] <= r_cnt[w_gnt] + 32'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[i*32 +: 32] = r_cnt[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_mul_arbiter.sv
// tb_fir_mul_arbiter: scoreboard bench for fir_mul_arbiter.
// A 7-stage multiplier model feeds mul_q back to the DUT.
module tb_fir_mul_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 7;

  typedef struct {
    logic [1:0]    id;
    logic [2*W-1:0] q;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_q, res_q;
  logic           res_valid;
  logic [1:0]     res_id;
  logic           flush = 1'b0;
  logic           idle;
  logic [3:0]     inflight;
  logic [N*32-1:0] grant_cnt;

  logic [W-1:0]   op_a [N];
  logic [W-1:0]   op_b [N];
  logic [2*W-1:0] mp [L];

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  int n_res = 0;
  int cyc = 0;
  int exp_rr = 0;
  int exp_cnt [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  end

  always @(posedge clk) begin
    mp[0] <= mul_a * mul_b;
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  assign mul_q = mp[L-1];

  fir_mul_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_q(mul_q),
    .res_valid(res_valid), .res_id(res_id), .res_q(res_q),
    .flush(flush), .idle(idle), .inflight(inflight),
    .grant_cnt(grant_cnt)
  );

  always @(negedge clk) begin
    if (rstn && res_valid) begin
      exp_t e;
      n_res++;
      n_chk++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result id=%0d q=%h", res_id, res_q);
      end else begin
        e = sb.pop_front();
        if (res_id !== e.id || res_q !== e.q || cyc !== e.cyc + 8) begin
          n_err++;
          $display("FAIL result got id=%0d q=%h cyc=%0d exp id=%0d q=%h cyc=%0d",
                   res_id, res_q, cyc, e.id, e.q, e.cyc + 8);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'($urandom_range(0, 65535));
      op_b[i] = W'($urandom_range(0, 65535));
    end
  endtask

  task automatic expect_fire(input int g);
    exp_t e;
    e.id  = 2'(g);
    e.q   = op_a[g] * op_b[g];
    e.cyc = cyc;
    sb.push_back(e);
    exp_cnt[g]++;
    exp_rr = (g + 1) % N;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inflight == 0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      exp_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({req_ready, mul_a, mul_b, res_valid, res_id, res_q, idle, inflight} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs rdy=%b a=%h b=%h rv=%b id=%0d q=%h idle=%b inf=%0d",
               req_ready, mul_a, mul_b, res_valid, res_id, res_q, idle, inflight);
    end
    n_chk++;
    if (grant_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_grant_cnt got %h exp 0", grant_cnt);
    end
  endtask

  task automatic test_single();
    bit got;
    int fcyc;
    step();
    op_a[0] = 16'd3;
    op_b[0] = 16'd5;
    req_valid = 4'b0001;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL single_ready got %b exp 0001", req_ready);
    end
    expect_fire(0);
    fcyc = cyc;
    step();
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (inflight !== 4'd1) begin
      n_err++;
      $display("FAIL single_inflight1 got %0d exp 1", inflight);
    end
    got = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!got || cyc - fcyc != 8 || res_q !== 32'd15 || res_id !== 2'd0) begin
      n_err++;
      $display("FAIL single_result got v=%b lat=%0d q=%h id=%0d exp lat=8 q=f id=0",
               got, cyc - fcyc, res_q, res_id);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (inflight !== 4'd0) begin
      n_err++;
      $display("FAIL single_inflight0 got %0d exp 0", inflight);
    end
  endtask

  task automatic test_all4();
    bit ok;
    logic [N-1:0] expv;
    for (int c = 0; c < 12; c++) begin
      step();
      rand_ops();
      req_valid = 4'b1111;
      @(negedge clk);
      expv = '0;
      expv[exp_rr] = 1'b1;
      n_chk++;
      if (req_ready !== expv) begin
        n_err++;
        $display("FAIL all4_grant c=%0d got %b exp %b", c, req_ready, expv);
      end
      expect_fire(exp_rr);
    end
    step();
    req_valid = '0;
    wait_drain(ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL all4_drain got inflight=%0d pending=%0d exp 0", inflight, sb.size());
    end
  endtask

  task automatic test_max();
    bit got;
    step();
    op_a[2] = 16'hFFFF;
    op_b[2] = 16'hFFFF;
    req_valid = 4'b0100;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL max_ready got %b exp 0100", req_ready);
    end
    expect_fire(2);
    step();
    req_valid = '0;
    got = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!got || res_q !== 32'hFFFE0001 || res_id !== 2'd2) begin
      n_err++;
      $display("FAIL max_result got v=%b q=%h id=%0d exp q=fffe0001 id=2",
               got, res_q, res_id);
    end
    step();
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    int r0;
    logic [N-1:0] expv;
    for (int c = 0; c < 5; c++) begin
      step();
      rand_ops();
      req_valid = 4'b1111;
      @(negedge clk);
      expv = '0;
      expv[exp_rr] = 1'b1;
      n_chk++;
      if (req_ready !== expv) begin
        n_err++;
        $display("FAIL flush_pre_grant got %b exp %b", req_ready, expv);
      end
      expect_fire(exp_rr);
    end
    r0 = n_res;
    step();
    flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0000 || inflight !== 4'd5) begin
      n_err++;
      $display("FAIL flush_same_cycle got rdy=%b inf=%0d exp rdy=0000 inf=5",
               req_ready, inflight);
    end
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      @(negedge clk);
      n_chk++;
      if (req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL flush_no_grant got %b exp 0000", req_ready);
      end
      if (idle) begin
        seen = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!seen || inflight !== 4'd0 || n_res - r0 != 5 || sb.size() != 0) begin
      n_err++;
      $display("FAIL flush_idle got idle=%b inf=%0d res=%0d exp idle=1 inf=0 res=5",
               seen, inflight, n_res - r0);
    end
    step();
    flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0000 || idle !== 1'b1) begin
      n_err++;
      $display("FAIL flush_exit_cycle got rdy=%b idle=%b exp rdy=0000 idle=1",
               req_ready, idle);
    end
    step();
    @(negedge clk);
    expv = '0;
    expv[exp_rr] = 1'b1;
    n_chk++;
    if (req_ready !== expv || idle !== 1'b0) begin
      n_err++;
      $display("FAIL flush_resume got rdy=%b idle=%b exp rdy=%b idle=0",
               req_ready, idle, expv);
    end
    expect_fire(exp_rr);
    step();
    req_valid = '0;
    wait_drain(ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL flush_drain got inflight=%0d pending=%0d exp 0", inflight, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    logic [N-1:0] expv;
    for (int c = 0; c < 4; c++) begin
      step();
      rand_ops();
      req_valid = 4'b1111;
      @(negedge clk);
      expv = '0;
      expv[exp_rr] = 1'b1;
      n_chk++;
      if (req_ready !== expv) begin
        n_err++;
        $display("FAIL rst_pre_grant got %b exp %b", req_ready, expv);
      end
      expect_fire(exp_rr);
    end
    step();
    rstn = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_no_grant got %b exp 0000", req_ready);
    end
    step();
    rstn = 1'b1;
    req_valid = '0;
    sb.delete();
    exp_rr = 0;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    @(negedge clk);
    n_chk++;
    if ({mul_a, mul_b, res_valid, idle, inflight} !== '0 || grant_cnt !== '0) begin
      n_err++;
      $display("FAIL rst_outputs got a=%h b=%h rv=%b idle=%b inf=%0d cnt=%h exp 0",
               mul_a, mul_b, res_valid, idle, inflight, grant_cnt);
    end
    r0 = n_res;
    repeat (12) step();
    n_chk++;
    if (n_res != r0) begin
      n_err++;
      $display("FAIL rst_discard got %0d results exp 0", n_res - r0);
    end
    step();
    rand_ops();
    req_valid = 4'b1111;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_rr_ptr got %b exp 0001", req_ready);
    end
    expect_fire(0);
    step();
    req_valid = '0;
  endtask

  task automatic test_sparse();
    bit ok;
    int seq [3] = '{3, 1, 3};
    logic [N-1:0] expv;
    step();
    rand_ops();
    req_valid = 4'b0010;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL sparse_setup got %b exp 0010", req_ready);
    end
    expect_fire(1);
    for (int c = 0; c < 3; c++) begin
      step();
      rand_ops();
      req_valid = 4'b1010;
      @(negedge clk);
      expv = '0;
      expv[seq[c]] = 1'b1;
      n_chk++;
      if (req_ready !== expv) begin
        n_err++;
        $display("FAIL sparse_grant c=%0d got %b exp %b", c, req_ready, expv);
      end
      expect_fire(seq[c]);
    end
    step();
    req_valid = '0;
    wait_drain(ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL sparse_drain got inflight=%0d pending=%0d exp 0", inflight, sb.size());
    end
    for (int i = 0; i < N; i++) begin
      n_chk++;
`ifdef FIR_MUL_ARB_GRANT_CNT_EN
      if (grant_cnt[i*32 +: 32] !== 32'(exp_cnt[i])) begin
        n_err++;
        $display("FAIL grant_cnt[%0d] got %0d exp %0d", i, grant_cnt[i*32 +: 32], exp_cnt[i]);
      end
`else
      if (grant_cnt[i*32 +: 32] !== 32'd0) begin
        n_err++;
        $display("FAIL grant_cnt[%0d] got %0d exp 0", i, grant_cnt[i*32 +: 32]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_max();
    test_flush();
    test_reset_mid();
    test_sparse();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
